// File: rtl/series_pkg.sv
// Shared types and default widths for the series dispatcher slice.
package series_pkg;

  localparam int W     = 8;
  localparam int RES_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4,
    S_DONE      = 3'd5
  } disp_state_t;

endpackage

// File: rtl/series_dispatcher_if.sv
// Host operand/result streams plus the engine handshake, bundled for the dispatcher.
interface series_dispatcher_if #(
  parameter int W     = series_pkg::W,
  parameter int RES_W = series_pkg::RES_W,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_res;
  logic             eng_start;
  logic [W-1:0]     eng_x;
  logic [W-1:0]     eng_y;
  logic             eng_ready;
  logic [RES_W-1:0] eng_res;
  logic             busy;
  logic [CW-1:0]    count;

  // The dispatcher side; the host/engine environment uses master.
  modport slave (
    input  in_valid, in_x, in_y, out_ready, eng_ready, eng_res,
    output in_ready, out_valid, out_res, eng_start, eng_x, eng_y, busy, count
  );

  modport master (
    output in_valid, in_x, in_y, out_ready, eng_ready, eng_res,
    input  in_ready, out_valid, out_res, eng_start, eng_x, eng_y, busy, count
  );

endinterface

// File: rtl/series_fifo.sv
// Small synchronous FIFO; pointers wrap modulo DEPTH and the count tells full from empty.
module series_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO's contents are never consumed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/series_dispatcher.sv
// Queues host operand pairs, runs the series engine once per pair and holds each result for the host.
module series_dispatcher #(
  parameter int W     = series_pkg::W,
  parameter int RES_W = series_pkg::RES_W,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  series_dispatcher_if.slave bus
);
  import series_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  disp_state_t      state;
  disp_state_t      state_next;
  logic [2*W-1:0]   head;
  logic [CW-1:0]    fifo_count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             res_free;
  logic             start_q;
  logic             out_valid_q;
  logic [RES_W-1:0] out_res_q;

  assign push     = bus.in_valid && !full;
  assign pop      = (state == S_DONE);
  assign res_free = !out_valid_q || bus.out_ready;

  series_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.in_x, bus.in_y}),
    .head  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // The head stays put until S_DONE pops it, since the engine loads x/y late.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!empty && bus.eng_ready) state_next = S_START;
      S_START:     state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.eng_ready) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.eng_ready) state_next = res_free ? S_DONE : S_HOLD;
      S_HOLD:      if (res_free) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // A capture in S_DONE wins over a consume in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
    end else begin
      start_q <= (state_next == S_START);
      if (state == S_DONE) begin
        out_res_q   <= bus.eng_res;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.eng_start = start_q;
  assign bus.eng_x     = head[2*W-1:W];
  assign bus.eng_y     = head[W-1:0];
  assign bus.busy      = (state != S_IDLE);
  assign bus.count     = fifo_count;

endmodule

// File: tb/tb_series_dispatcher.sv
// Directed, table-driven and randomized checks of series_dispatcher against an in-order result queue.
module tb_series_dispatcher;
  import series_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  series_dispatcher_if #(.W(8), .RES_W(16), .DEPTH(DEPTH)) bus ();

  series_dispatcher #(.W(8), .RES_W(16), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          starts = 0;
  int          got    = 0;
  logic [15:0] exp_q[$];
  logic        prev_start = 1'b0;
  logic [7:0]  held_x = '0;
  logic [7:0]  held_y = '0;
  logic        block_ready = 1'b0;
  logic        rand_lat = 1'b0;
  logic        rnd_done = 1'b0;

  // Engine result rule: x*y plus a fixed offset, so (3,5) gives 16'h1234.
  function automatic logic [15:0] refRes(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = {8'd0, x} * {8'd0, y};
    return p + 16'h1225;
  endfunction

  // Engine model: loads x/y two cycles after the start strobe and stays busy for a set latency.
  int          eng_phase;
  int          eng_cnt;
  logic        eng_rdy;
  logic [15:0] eng_acc;
  logic [15:0] eng_res_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_phase <= 0;
      eng_cnt   <= 0;
      eng_rdy   <= 1'b1;
      eng_acc   <= '0;
      eng_res_q <= '0;
    end else begin
      case (eng_phase)
        0: if (bus.eng_start) eng_phase <= 1;
        1: begin
          eng_acc   <= refRes(bus.eng_x, bus.eng_y);
          eng_rdy   <= 1'b0;
          eng_cnt   <= rand_lat ? int'($urandom_range(1, 12)) : 10;
          eng_phase <= 2;
        end
        default: begin
          if (eng_cnt <= 1) begin
            eng_rdy   <= 1'b1;
            eng_res_q <= eng_acc;
            eng_phase <= 0;
          end else begin
            eng_cnt <= eng_cnt - 1;
          end
        end
      endcase
    end
  end

  assign bus.eng_ready = eng_rdy && !block_ready;
  assign bus.eng_res   = eng_res_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyReset();
    rst = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [15:0] res);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    for (int k = 0; k < 2000 && !bus.in_ready; k++) tick();
    if (bus.in_ready) begin
      exp_q.push_back(res);
      tick();
    end else begin
      checkOutput("in_ready timeout", 32'(bus.in_ready), 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input string name);
    for (int k = 0; k < 500 && !bus.out_valid; k++) tick();
    checkOutput(name, 32'(bus.out_valid), 1);
  endtask

  task automatic waitEng(input logic level);
    for (int k = 0; k < 500 && bus.eng_ready !== level; k++) tick();
    checkOutput("eng_ready wait", 32'(bus.eng_ready), 32'(level));
  endtask

  task automatic waitStarts(input int n);
    for (int k = 0; k < 500 && starts < n; k++) tick();
    checkOutput("start count wait", starts, n);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0 && !bus.busy && bus.count == 0) break;
      tick();
    end
    checkOutput("drain results", exp_q.size(), 0);
    checkOutput("drain busy", 32'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   s0;
    int   g0;
    logic [7:0] rx;
    logic [7:0] ry;

    vecs[0] = '{x: 8'd0,   y: 8'd0,   res: 16'h1225};
    vecs[1] = '{x: 8'd255, y: 8'd255, res: 16'h1026};
    vecs[2] = '{x: 8'd16,  y: 8'd16,  res: 16'h1325};
    vecs[3] = '{x: 8'd12,  y: 8'd11,  res: 16'h12A9};

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;

    // Monitor: start pulse shape, operand hold, in_ready rule and in-order results.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (bus.eng_start) begin
            checkOutput("single start pulse", 32'(prev_start), 0);
            starts++;
            held_x = bus.eng_x;
            held_y = bus.eng_y;
          end else if (bus.busy) begin
            checkOutput("eng_x hold", 32'(bus.eng_x), 32'(held_x));
            checkOutput("eng_y hold", 32'(bus.eng_y), 32'(held_y));
          end
          checkOutput("in_ready vs count", 32'(bus.in_ready), 32'(bus.count < DEPTH));
          if (bus.out_valid && bus.out_ready) begin
            checkOutput("spurious result", 32'(exp_q.size() == 0), 0);
            if (exp_q.size() != 0) checkOutput("result order", 32'(bus.out_res), 32'(exp_q.pop_front()));
            got++;
          end
          prev_start = bus.eng_start;
        end else begin
          prev_start = 1'b0;
        end
      end
    join_none

    applyReset();
    checkOutput("reset in_ready", 32'(bus.in_ready), 1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 0);
    checkOutput("reset out_res", 32'(bus.out_res), 0);
    checkOutput("reset eng_start", 32'(bus.eng_start), 0);
    checkOutput("reset busy", 32'(bus.busy), 0);
    checkOutput("reset count", 32'(bus.count), 0);

    $display("[TB] single operand latency");
    s0 = starts;
    applyStimulus(8'd3, 8'd5, 16'h1234);
    checkOutput("start after push", 32'(bus.eng_start), 0);
    checkOutput("count after push", 32'(bus.count), 1);
    tick();
    checkOutput("start strobe", 32'(bus.eng_start), 1);
    checkOutput("eng_x at start", 32'(bus.eng_x), 3);
    checkOutput("eng_y at start", 32'(bus.eng_y), 5);
    tick();
    checkOutput("start drops", 32'(bus.eng_start), 0);
    waitOutValid("first result valid");
    checkOutput("first result", 32'(bus.out_res), 32'h1234);
    checkOutput("count drained", 32'(bus.count), 0);
    checkOutput("one start", starts - s0, 1);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("out_valid consumed", 32'(bus.out_valid), 0);

    $display("[TB] engine not ready blocks start");
    block_ready = 1'b1;
    s0 = starts;
    applyStimulus(8'd9, 8'd4, refRes(8'd9, 8'd4));
    repeat (5) tick();
    checkOutput("blocked busy", 32'(bus.busy), 0);
    checkOutput("blocked starts", starts - s0, 0);
    block_ready = 1'b0;
    waitDrain();

    $display("[TB] table: four back-to-back pairs");
    s0 = starts;
    g0 = got;
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i].x, vecs[i].y, vecs[i].res);
    checkOutput("full in_ready", 32'(bus.in_ready), 0);
    checkOutput("full count", 32'(bus.count), 4);
    bus.in_valid = 1'b1;
    bus.in_x     = 8'hAA;
    bus.in_y     = 8'h55;
    repeat (3) tick();
    checkOutput("push while full ignored", 32'(bus.count), 4);
    bus.in_valid = 1'b0;
    waitDrain();
    checkOutput("table starts", starts - s0, 4);
    checkOutput("table results", got - g0, 4);

    $display("[TB] hold with result pending");
    bus.out_ready = 1'b0;
    s0 = starts;
    g0 = got;
    applyStimulus(8'd7, 8'd9, refRes(8'd7, 8'd9));
    applyStimulus(8'd200, 8'd3, refRes(8'd200, 8'd3));
    waitStarts(s0 + 2);
    waitEng(1'b0);
    waitEng(1'b1);
    repeat (2) tick();
    checkOutput("hold busy", 32'(bus.busy), 1);
    checkOutput("hold count", 32'(bus.count), 1);
    checkOutput("hold first held", 32'(bus.out_res), 32'(refRes(8'd7, 8'd9)));
    checkOutput("hold nothing consumed", got - g0, 0);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("done cycle out_valid", 32'(bus.out_valid), 0);
    tick();
    checkOutput("second captured", 32'(bus.out_res), 32'(refRes(8'd200, 8'd3)));
    checkOutput("second valid", 32'(bus.out_valid), 1);
    waitDrain();
    checkOutput("hold results", got - g0, 2);

    $display("[TB] push and pop together with wrap");
    applyReset();
    bus.out_ready = 1'b0;
    s0 = starts;
    applyStimulus(8'd1, 8'd2, refRes(8'd1, 8'd2));
    waitOutValid("p0 valid");
    applyStimulus(8'd3, 8'd4, refRes(8'd3, 8'd4));
    applyStimulus(8'd5, 8'd6, refRes(8'd5, 8'd6));
    waitStarts(s0 + 2);
    waitEng(1'b0);
    waitEng(1'b1);
    repeat (2) tick();
    checkOutput("pre pushpop count", 32'(bus.count), 2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 8'd7;
    bus.in_y      = 8'd8;
    exp_q.push_back(refRes(8'd7, 8'd8));
    tick();
    bus.in_valid = 1'b0;
    checkOutput("pushpop count", 32'(bus.count), 2);
    bus.out_ready = 1'b1;
    applyStimulus(8'd9, 8'd10, refRes(8'd9, 8'd10));
    applyStimulus(8'd11, 8'd12, refRes(8'd11, 8'd12));
    waitDrain();

    $display("[TB] reset during run");
    applyReset();
    s0 = starts;
    applyStimulus(8'd20, 8'd21, refRes(8'd20, 8'd21));
    applyStimulus(8'd22, 8'd23, refRes(8'd22, 8'd23));
    applyStimulus(8'd24, 8'd25, refRes(8'd24, 8'd25));
    waitEng(1'b0);
    repeat (2) tick();
    checkOutput("pre reset count", 32'(bus.count), 3);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid reset count", 32'(bus.count), 0);
    checkOutput("mid reset out_valid", 32'(bus.out_valid), 0);
    checkOutput("mid reset eng_start", 32'(bus.eng_start), 0);
    checkOutput("mid reset busy", 32'(bus.busy), 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    repeat (20) tick();
    checkOutput("no start after reset", starts - s0, 1);
    checkOutput("idle after reset", 32'(bus.busy), 0);
    applyStimulus(8'd30, 8'd31, refRes(8'd30, 8'd31));
    waitDrain();

    $display("[TB] randomized traffic");
    applyReset();
    rand_lat = 1'b1;
    rnd_done = 1'b0;
    g0 = got;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          rx = 8'($urandom);
          ry = 8'($urandom);
          applyStimulus(rx, ry, refRes(rx, ry));
        end
        rnd_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000 && !rnd_done; c++) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("random results", got - g0, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
